vit_frame_ctrl: RTL and testbench

- Frame sequencer for the Viterbi decoder front end. Accepts received symbol pairs over a valid/ready handshake and presents one registered pair per trellis step to the branch-metric units, together with a step strobe for the ACS array.
- Flags the tail (termination) steps of each frame, then hands off to traceback and stalls input until traceback completes.
- Sits between the channel input FIFO and the bmc/ACS/traceback datapath.

---
 rtl/vit_pkg.sv | 16 +
 rtl/vit_step_cnt.sv | 34 +++
 rtl/vit_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_vit_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// Shared types and default frame geometry for the Viterbi decoder front end.
package vit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        TB_REQ,
        WAIT_TB
    } vit_ctrl_state_t;

    typedef logic [1:0] rx_pair_t;

    localparam int VIT_FRAME_LEN = 64;
    localparam int VIT_TAIL_LEN  = 2;

endpackage

// File: rtl/vit_step_cnt.sv
// Loadable trellis step counter that wraps at FRAME_LEN-1.
// Also flags the terminal step and the tail region of the frame.
module vit_step_cnt #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last,
    output logic             tail
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] TAIL_IDX = CNT_W'(FRAME_LEN - TAIL_LEN);

    assign last = (count == LAST_IDX);
    assign tail = (count >= TAIL_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vit_frame_ctrl.sv
// Viterbi frame sequencer: feeds one registered pair per trellis step, then hands off to traceback.
// Optional traceback watchdog with sticky tb_err output: define VIT_TB_WATCHDOG_EN.
module vit_frame_ctrl
    import vit_pkg::*;
#(
    parameter int FRAME_LEN  = VIT_FRAME_LEN,
    parameter int TAIL_LEN   = VIT_TAIL_LEN,
    parameter int CNT_W      = 8,
    parameter int TB_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  rx_pair_t         rx_pair,
    output rx_pair_t         bmc_pair,
    output logic             step_en,
    output logic [CNT_W-1:0] step_idx,
    output logic             tail_phase,
    output logic             acs_init,
    output logic             tb_start,
    input  logic             tb_done,
    output logic             frame_done,
    output logic             busy
`ifdef VIT_TB_WATCHDOG_EN
    ,
    output logic             tb_err
`endif
);

    vit_ctrl_state_t state;
    vit_ctrl_state_t next_state;

    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_tail;
    logic             wd_expire;

    assign in_ready = (state == ACQ);
    assign accept   = in_valid & in_ready;

    vit_step_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .TAIL_LEN  (TAIL_LEN),
        .CNT_W     (CNT_W)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE),
        .load_val ('0),
        .inc      (accept),
        .count    (cnt),
        .last     (cnt_last),
        .tail     (cnt_tail)
    );

`ifdef VIT_TB_WATCHDOG_EN
    localparam logic [CNT_W:0] WD_LIMIT = (CNT_W + 1)'(TB_TIMEOUT - 1);

    logic [CNT_W:0] wd_cnt;

    assign wd_expire = (state == WAIT_TB) && (wd_cnt == WD_LIMIT);

    // The watchdog counts cycles spent in WAIT_TB; a late tb_done still beats the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            tb_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_TB) ? wd_cnt + 1'b1 : '0;
            if (wd_expire && !tb_done) begin
                tb_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TB_TIMEOUT;
    assign wd_expire      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = ACQ;
            ACQ:     if (accept && cnt_last) next_state = TB_REQ;
            TB_REQ:  next_state = WAIT_TB;
            WAIT_TB: if (tb_done || wd_expire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // tb_start is raised on the final accept so it lands in the same cycle as the last step_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            bmc_pair   <= 2'b00;
            step_en    <= 1'b0;
            step_idx   <= '0;
            tail_phase <= 1'b0;
            acs_init   <= 1'b0;
            tb_start   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b1;
        end else begin
            step_en    <= accept;
            tail_phase <= accept & cnt_tail;
            acs_init   <= (state == IDLE);
            tb_start   <= accept & cnt_last;
            frame_done <= (state == WAIT_TB) & tb_done;
            busy       <= !(next_state == ACQ &&
                            (state == IDLE || (cnt == '0 && !accept)));
            if (accept) begin
                bmc_pair <= rx_pair;
                step_idx <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Self-checking bench for vit_frame_ctrl with FRAME_LEN=8, TAIL_LEN=2, TB_TIMEOUT=16.
module tb_vit_frame_ctrl;

    localparam int FL = 8;
    localparam int TL = 2;
    localparam int CW = 8;
    localparam int TO = 16;

    typedef struct {
        logic [1:0] pair;
        int         idx;
        logic       tail;
    } step_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    rx_pair;
    logic [1:0]    bmc_pair;
    logic          step_en;
    logic [CW-1:0] step_idx;
    logic          tail_phase;
    logic          acs_init;
    logic          tb_start;
    logic          tb_done;
    logic          frame_done;
    logic          busy;
`ifdef VIT_TB_WATCHDOG_EN
    logic          tb_err;
`endif

    int    tests = 0;
    int    fails = 0;
    int    exp_idx;
    step_t exp_q[$];
    step_t mon_e;
    logic [1:0] last_pair;

    vit_frame_ctrl #(
        .FRAME_LEN  (FL),
        .TAIL_LEN   (TL),
        .CNT_W      (CW),
        .TB_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rx_pair    (rx_pair),
        .bmc_pair   (bmc_pair),
        .step_en    (step_en),
        .step_idx   (step_idx),
        .tail_phase (tail_phase),
        .acs_init   (acs_init),
        .tb_start   (tb_start),
        .tb_done    (tb_done),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef VIT_TB_WATCHDOG_EN
        ,
        .tb_err     (tb_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one ACQ cycle; accepted pairs are queued with their expected step attributes.
    task automatic applyStimulus(input logic valid, input logic [1:0] pair);
        checkOutput("in_ready_acq", int'(in_ready), 1);
        in_valid = valid;
        rx_pair  = pair;
        if (valid) begin
            exp_q.push_back('{pair: pair, idx: exp_idx, tail: (exp_idx >= FL - TL)});
            exp_idx++;
            last_pair = pair;
        end
        tick();
    endtask

    task automatic streamFrame();
        exp_idx = 0;
        for (int i = 0; i < FL; i++) begin
            applyStimulus(1'b1, 2'(i));
        end
        in_valid = 1'b0;
        checkOutput("tb_start_last", int'(tb_start), 1);
        checkOutput("in_ready_after", int'(in_ready), 0);
        checkOutput("busy_tb_req", int'(busy), 1);
        #2;
        checkOutput("queue_drained", exp_q.size(), 0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_bmc_pair", int'(bmc_pair), 0);
        checkOutput("rst_step_en", int'(step_en), 0);
        checkOutput("rst_step_idx", int'(step_idx), 0);
        checkOutput("rst_tail", int'(tail_phase), 0);
        checkOutput("rst_acs_init", int'(acs_init), 0);
        checkOutput("rst_tb_start", int'(tb_start), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_busy", int'(busy), 1);
    endtask

    // Scoreboard: every step_en must match the oldest accepted pair.
    always @(posedge clk) begin
        #2;
        if (step_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_step_en", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("bmc_pair", int'(bmc_pair), int'(mon_e.pair));
                checkOutput("step_idx", int'(step_idx), mon_e.idx);
                checkOutput("tail_phase", int'(tail_phase), int'(mon_e.tail));
                checkOutput("tb_start_step", int'(tb_start), int'(mon_e.idx == FL - 1));
            end
        end else begin
            checkOutput("tb_start_idle", int'(tb_start), 0);
            checkOutput("tail_idle", int'(tail_phase), 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        rx_pair   = 2'b00;
        tb_done   = 1'b0;
        last_pair = 2'b00;
        exp_idx   = 0;
        repeat (3) tick();
        checkResetValues();

        rst = 1'b0;
        tick();
        checkOutput("init_acs_init", int'(acs_init), 1);
        checkOutput("init_in_ready", int'(in_ready), 1);
        checkOutput("init_busy", int'(busy), 0);

        $display("[TB] frame 1: back-to-back stream");
        streamFrame();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("wait_in_ready", int'(in_ready), 0);
            checkOutput("wait_frame_done", int'(frame_done), 0);
        end
        tick();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        checkOutput("frame_done_pulse", int'(frame_done), 1);
        checkOutput("fd_acs_init", int'(acs_init), 0);
        checkOutput("fd_in_ready", int'(in_ready), 0);
        tick();
        checkOutput("fd_cleared", int'(frame_done), 0);
        checkOutput("rearm_acs_init", int'(acs_init), 1);
        checkOutput("rearm_in_ready", int'(in_ready), 1);

        $display("[TB] frame 2: gapped input then reset mid-frame");
        exp_idx = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2) == 0, 2'($urandom_range(0, 3)));
            if ((i % 2) != 0) begin
                checkOutput("gap_step_en", int'(step_en), 0);
                checkOutput("gap_bmc_hold", int'(bmc_pair), int'(last_pair));
            end
        end
        applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        rst      = 1'b1;
        in_valid = 1'b1;
        rx_pair  = 2'b11;
        tick();
        checkResetValues();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("post_rst_frame_done", int'(frame_done), 0);
        checkOutput("post_rst_acs_init", int'(acs_init), 1);
        #2;
        checkOutput("rst_queue_drained", exp_q.size(), 0);

        $display("[TB] frame 3: restart at idx 0, early tb_done ignored");
        streamFrame();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        checkOutput("early_tb_done_ignored", int'(frame_done), 0);
        tick();
        checkOutput("waiting_no_done", int'(frame_done), 0);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        checkOutput("frame3_done", int'(frame_done), 1);
        tick();
        checkOutput("frame3_rearm", int'(acs_init), 1);

`ifdef VIT_TB_WATCHDOG_EN
        $display("[TB] frame 4: traceback watchdog");
        streamFrame();
        for (int i = 0; i < TO; i++) begin
            tick();
            checkOutput("wd_no_done", int'(frame_done), 0);
        end
        checkOutput("wd_err_before", int'(tb_err), 0);
        tick();
        checkOutput("wd_err_set", int'(tb_err), 1);
        checkOutput("wd_no_frame_done", int'(frame_done), 0);
        tick();
        checkOutput("wd_rearm_acs_init", int'(acs_init), 1);
        checkOutput("wd_rearm_in_ready", int'(in_ready), 1);
        repeat (3) tick();
        checkOutput("wd_err_sticky", int'(tb_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("wd_err_cleared", int'(tb_err), 0);
        tick();
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
